// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer and its neighbours.
package mac_pkg;

   localparam int unsigned MAC_WIDTH_DEF = 32;
   localparam int unsigned MAC_LEN_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      STREAM,
      DRAIN,
      RESP
   } mac_seq_state_t;

endpackage

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: accepts a length-N command, streams N operand pairs
// into an external MAC, then returns the accumulator on a valid/ready port.
module mac_dot_seq
   import mac_pkg::*;
#(
   parameter int unsigned WIDTH = MAC_WIDTH_DEF,
   parameter int unsigned LEN_W = MAC_LEN_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               mac_en,
   output logic               mac_clr,
   output logic [WIDTH-1:0]   mac_a,
   output logic [WIDTH-1:0]   mac_b,
   input  logic [2*WIDTH-1:0] mac_acc,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_data,
   output logic               busy
);

   mac_seq_state_t   state_q, state_d;
   logic [LEN_W-1:0] rem_q;
   logic             cmd_fire;
   logic             in_fire;

   assign cmd_fire = cmd_valid & cmd_ready;
   assign in_fire  = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      mac_clr   = 1'b0;
      res_valid = 1'b0;
      res_data  = '0;
      busy      = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = CLR;
         end
         CLR: begin
            mac_clr = 1'b1;
            state_d = (rem_q == '0) ? DRAIN : STREAM;
         end
         STREAM: begin
            in_ready = 1'b1;
            if (in_valid && rem_q == LEN_W'(1)) state_d = DRAIN;
         end
         DRAIN: state_d = RESP;
         RESP: begin
            res_valid = 1'b1;
            res_data  = mac_acc;
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // mac_en is a one-cycle echo of each STREAM handshake; operands hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         mac_en <= 1'b0;
         mac_a  <= '0;
         mac_b  <= '0;
      end else begin
         mac_en <= 1'b0;
         if (cmd_fire) rem_q <= cmd_len;
         if (in_fire) begin
            mac_a  <= in_a;
            mac_b  <= in_b;
            mac_en <= 1'b1;
            rem_q  <= rem_q - LEN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural MAC beside it.
module tb_mac_dot_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [15:0] cmd_len;
   logic        in_valid, in_ready;
   logic [31:0] in_a, in_b;
   logic        mac_en, mac_clr;
   logic [31:0] mac_a, mac_b;
   logic [63:0] mac_acc;
   logic        res_valid, res_ready;
   logic [63:0] res_data;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int en_cnt = 0;
   int clr_cnt = 0;

   typedef struct {
      int          n;
      logic [31:0] a[4];
      logic [31:0] b[4];
      bit          toggle;
      int          hold;
      logic [63:0] exp;
      int          lat;
   } job_t;

   job_t jobs[7];
   job_t last_job;

   always #5 clk = ~clk;

   mac_dot_seq #(.WIDTH(32), .LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
      .mac_acc(mac_acc),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy)
   );

   // Accumulator model standing in for the neighbouring mac instance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       mac_acc <= '0;
      else if (mac_clr) mac_acc <= '0;
      else if (mac_en)  mac_acc <= mac_acc + 64'(mac_a) * 64'(mac_b);
   end

   always @(negedge clk) begin
      if (mac_en)  en_cnt++;
      if (mac_clr) clr_cnt++;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic job_t mk(input int n,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic [31:0] a2, input logic [31:0] b2,
                               input logic [31:0] a3, input logic [31:0] b3,
                               input bit tg, input int hold,
                               input logic [63:0] e, input int lat);
      job_t j;
      j.n = n;
      j.a[0] = a0; j.a[1] = a1; j.a[2] = a2; j.a[3] = a3;
      j.b[0] = b0; j.b[1] = b1; j.b[2] = b2; j.b[3] = b3;
      j.toggle = tg; j.hold = hold; j.exp = e; j.lat = lat;
      return j;
   endfunction

   // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
   task automatic run_job(input job_t j);
      int idx = 0;
      int lat = 0;
      bit phase = 1'b1;
      bit hs;
      int budget = j.n * 3 + 20;
      en_cnt  = 0;
      clr_cnt = 0;
      cmd_len   = 16'(j.n);
      cmd_valid = 1'b1;
      res_ready = (j.hold == 0);
      check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      while (!res_valid && lat < budget) begin
         in_valid = (idx < j.n) && (!j.toggle || phase);
         in_a = j.a[idx & 3];
         in_b = j.b[idx & 3];
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) idx++;
         phase = ~phase;
         lat++;
      end
      in_valid = 1'b0;
      if (!res_valid) begin
         check("res_timeout", 64'(res_valid), 64'd1);
         return;
      end
      if (j.lat >= 0) check("latency", 64'(lat), 64'(j.lat));
      for (int h = 0; h < j.hold; h++) begin
         cmd_valid = 1'b1;
         in_valid  = 1'b1;
         check("hold_res_valid", 64'(res_valid), 64'd1);
         check("hold_res_data", res_data, j.exp);
         check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      in_valid  = 1'b0;
      check("res_data", res_data, j.exp);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("res_valid_one_cycle", 64'(res_valid), 64'd0);
      check("busy_after", 64'(busy), 64'd0);
      check("en_pulses", 64'(en_cnt), 64'(j.n));
      check("clr_pulses", 64'(clr_cnt), 64'd1);
   endtask

   initial begin
      jobs[0] = mk(3, 2, 3, 4, 5, 6, 7, 0, 0, 1'b0, 0, 64'd68, 5);
      jobs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 64'd0, 2);
      jobs[2] = mk(4, 1, 1, 2, 2, 3, 3, 4, 4, 1'b1, 0, 64'd30, -1);
      jobs[3] = mk(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0,
                   1'b0, 0, 64'hFFFFFFFE00000001, 3);
      jobs[4] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1'b0, 0, 64'd1, 3);
      jobs[5] = mk(2, 3, 4, 5, 6, 0, 0, 0, 0, 1'b0, 5, 64'd42, 4);
      jobs[6] = mk(65535, 1, 1, 1, 1, 1, 1, 1, 1, 1'b0, 0, 64'd65535, 65537);
      last_job = mk(1, 9, 9, 0, 0, 0, 0, 0, 0, 1'b0, 0, 64'd81, 3);

      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_len = '0;
      in_valid = 1'b0; in_a = '0; in_b = '0;
      res_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mac_en", 64'(mac_en), 64'd0);
      check("rst_mac_clr", 64'(mac_clr), 64'd0);
      check("rst_mac_a", 64'(mac_a), 64'd0);
      check("rst_mac_b", 64'(mac_b), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_data", res_data, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run_job(jobs[i]);

      // Reset in STREAM after two of five pairs; the job must vanish silently.
      cmd_len = 16'd5;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      in_valid = 1'b1; in_a = 32'd2; in_b = 32'd3;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("pre_rst_busy", 64'(busy), 64'd1);
      check("pre_rst_mac_en", 64'(mac_en), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_mac_en", 64'(mac_en), 64'd0);
      check("midrst_res_valid", 64'(res_valid), 64'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_res_valid", 64'(res_valid), 64'd0);
      run_job(last_job);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
